// File: rtl/orv64_ptw_walker_pkg.sv
// Shared Sv39 walker types, fault-cause encodings and access-type -> cause helpers.
package orv64_ptw_walker_pkg;

    localparam int unsigned ORV64_NUM_PAGE_LEVELS = 3;

    typedef logic [26:0] orv64_vpn_t;
    typedef logic [1:0]  orv64_ptw_lvl_t;
    typedef logic [3:0]  orv64_excp_cause_t;

    typedef enum logic [1:0] {
        ORV64_ACCESS_FETCH = 2'd0,
        ORV64_ACCESS_LOAD  = 2'd1,
        ORV64_ACCESS_STORE = 2'd2,
        ORV64_ACCESS_AMO   = 2'd3
    } orv64_access_type_t;

    typedef enum logic [1:0] {
        ORV64_PTW_IDLE,
        ORV64_PTW_MEM_REQ,
        ORV64_PTW_MEM_WAIT,
        ORV64_PTW_RESP
    } orv64_ptw_state_t;

    localparam orv64_excp_cause_t ORV64_EXCP_INST_ACCESS_FAULT  = 4'd1;
    localparam orv64_excp_cause_t ORV64_EXCP_LOAD_ACCESS_FAULT  = 4'd5;
    localparam orv64_excp_cause_t ORV64_EXCP_STORE_ACCESS_FAULT = 4'd7;
    localparam orv64_excp_cause_t ORV64_EXCP_INST_PAGE_FAULT    = 4'd12;
    localparam orv64_excp_cause_t ORV64_EXCP_LOAD_PAGE_FAULT    = 4'd13;
    localparam orv64_excp_cause_t ORV64_EXCP_STORE_PAGE_FAULT   = 4'd15;

    typedef struct packed {
        logic [3:0]  mode;
        logic [15:0] asid;
        logic [43:0] ppn;
    } orv64_csr_satp_t;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } orv64_pte_t;

    typedef struct packed {
        orv64_vpn_t         req_vpn;
        orv64_access_type_t req_access_type;
    } orv64_tlb_ptw_if_req_t;

    typedef struct packed {
        orv64_pte_t        resp_pte;
        orv64_ptw_lvl_t    resp_lvl;
        logic              resp_excp_valid;
        orv64_excp_cause_t resp_excp_cause;
    } orv64_tlb_ptw_if_resp_t;

    function automatic orv64_excp_cause_t orv64_get_fault_type(input orv64_access_type_t acc);
        case (acc)
            ORV64_ACCESS_FETCH: return ORV64_EXCP_INST_PAGE_FAULT;
            ORV64_ACCESS_LOAD:  return ORV64_EXCP_LOAD_PAGE_FAULT;
            default:            return ORV64_EXCP_STORE_PAGE_FAULT;
        endcase
    endfunction

    function automatic orv64_excp_cause_t orv64_get_excp_perm_type(input orv64_access_type_t acc);
        case (acc)
            ORV64_ACCESS_FETCH: return ORV64_EXCP_INST_ACCESS_FAULT;
            ORV64_ACCESS_LOAD:  return ORV64_EXCP_LOAD_ACCESS_FAULT;
            default:            return ORV64_EXCP_STORE_ACCESS_FAULT;
        endcase
    endfunction

    // Faults report no PTE and level 0 so the TLB never fills from them.
    function automatic orv64_tlb_ptw_if_resp_t orv64_fault_resp(input orv64_excp_cause_t cause);
        orv64_tlb_ptw_if_resp_t r;
        r                 = '0;
        r.resp_excp_valid = 1'b1;
        r.resp_excp_cause = cause;
        return r;
    endfunction

endpackage

// File: rtl/orv64_ptw_walker_pte_classifier.sv
// Combinational PTE decode: invalid encoding, leaf vs. pointer, misaligned superpage.
module orv64_ptw_walker_pte_classifier
    import orv64_ptw_walker_pkg::*;
(
    input  orv64_pte_t     i_pte,
    input  orv64_ptw_lvl_t i_lvl,
    output logic           o_is_invalid,
    output logic           o_is_leaf,
    output logic           o_is_misaligned
);

    logic w_unused;
    assign w_unused = ^{i_pte.reserved, i_pte.ppn[43:18], i_pte.rsw, i_pte.d, i_pte.a, i_pte.g, i_pte.u};

    always_comb begin
        o_is_invalid    = !i_pte.v || (!i_pte.r && i_pte.w);
        o_is_leaf       = i_pte.r || i_pte.x;
        o_is_misaligned = 1'b0;
        case (i_lvl)
            2'd2:    o_is_misaligned = |i_pte.ppn[17:0];
            2'd1:    o_is_misaligned = |i_pte.ppn[8:0];
            default: o_is_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/orv64_ptw_walker.sv
// Sv39 page-table walker: one request in flight, one outstanding PTE read at a time.
module orv64_ptw_walker
    import orv64_ptw_walker_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH = 56,
    parameter int unsigned NUM_LEVELS  = ORV64_NUM_PAGE_LEVELS
) (
    input  logic                   tlb_clkg,
    input  logic                   rstn,
    input  orv64_csr_satp_t        satp,
    input  logic                   tlb2ptw_req_valid,
    input  orv64_tlb_ptw_if_req_t  tlb2ptw_req,
    output logic                   ptw2tlb_req_ready,
    output logic                   ptw2tlb_resp_valid,
    output orv64_tlb_ptw_if_resp_t ptw2tlb_resp,
    input  logic                   tlb2ptw_resp_ready,
    output logic                   ptw2mem_req_valid,
    output logic [PADDR_WIDTH-1:0] ptw2mem_req_paddr,
    input  logic                   mem2ptw_req_ready,
    input  logic                   mem2ptw_resp_valid,
    input  logic [63:0]            mem2ptw_resp_data,
    input  logic                   mem2ptw_resp_err,
    output logic                   ptw_busy
);

    localparam orv64_ptw_lvl_t LVL_TOP = orv64_ptw_lvl_t'(NUM_LEVELS - 1);

    orv64_ptw_state_t       r_state;
    orv64_vpn_t             r_vpn;
    orv64_access_type_t     r_acc;
    orv64_ptw_lvl_t         r_lvl;
    logic [PADDR_WIDTH-1:0] r_paddr;
    logic                   r_req_ready;
    logic                   r_resp_valid;
    logic                   r_mem_req_valid;
    logic                   r_busy;
    orv64_tlb_ptw_if_resp_t r_resp;

    orv64_pte_t w_pte;
    logic       w_invalid;
    logic       w_leaf;
    logic       w_misaligned;
    logic       w_descend;
    logic       w_page_fault;
    logic       w_unused;

    assign w_pte    = orv64_pte_t'(mem2ptw_resp_data);
    assign w_unused = ^{satp.mode, satp.asid};

    orv64_ptw_walker_pte_classifier u_classifier (
        .i_pte           (w_pte),
        .i_lvl           (r_lvl),
        .o_is_invalid    (w_invalid),
        .o_is_leaf       (w_leaf),
        .o_is_misaligned (w_misaligned)
    );

    // Bus errors win over PTE content; a pointer at level 0 is a page fault.
    assign w_descend    = !mem2ptw_resp_err && !w_invalid && !w_leaf && (r_lvl != 2'd0);
    assign w_page_fault = w_invalid || !w_leaf || w_misaligned;

    function automatic logic [PADDR_WIDTH-1:0] pte_addr(input logic [43:0] ppn,
                                                        input orv64_vpn_t vpn,
                                                        input orv64_ptw_lvl_t lvl);
        logic [8:0] idx;
        case (lvl)
            2'd2:    idx = vpn[26:18];
            2'd1:    idx = vpn[17:9];
            default: idx = vpn[8:0];
        endcase
        return PADDR_WIDTH'({ppn, 12'h000}) + PADDR_WIDTH'({idx, 3'b000});
    endfunction

    always_ff @(posedge tlb_clkg) begin
        if (!rstn) begin
            r_state         <= ORV64_PTW_IDLE;
            r_vpn           <= '0;
            r_acc           <= ORV64_ACCESS_FETCH;
            r_lvl           <= '0;
            r_paddr         <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_resp          <= '0;
        end else begin
            case (r_state)
                ORV64_PTW_IDLE: begin
                    if (tlb2ptw_req_valid) begin
                        r_vpn           <= tlb2ptw_req.req_vpn;
                        r_acc           <= tlb2ptw_req.req_access_type;
                        r_lvl           <= LVL_TOP;
                        r_paddr         <= pte_addr(satp.ppn, tlb2ptw_req.req_vpn, LVL_TOP);
                        r_req_ready     <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= ORV64_PTW_MEM_REQ;
                    end
                end
                ORV64_PTW_MEM_REQ: begin
                    if (mem2ptw_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ORV64_PTW_MEM_WAIT;
                    end
                end
                ORV64_PTW_MEM_WAIT: begin
                    if (mem2ptw_resp_valid) begin
                        if (w_descend) begin
                            r_lvl           <= r_lvl - 2'd1;
                            r_paddr         <= pte_addr(w_pte.ppn, r_vpn, r_lvl - 2'd1);
                            r_mem_req_valid <= 1'b1;
                            r_state         <= ORV64_PTW_MEM_REQ;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_state      <= ORV64_PTW_RESP;
                            if (mem2ptw_resp_err)
                                r_resp <= orv64_fault_resp(orv64_get_excp_perm_type(r_acc));
                            else if (w_page_fault)
                                r_resp <= orv64_fault_resp(orv64_get_fault_type(r_acc));
                            else
                                r_resp <= '{resp_pte: w_pte, resp_lvl: r_lvl,
                                            resp_excp_valid: 1'b0, resp_excp_cause: '0};
                        end
                    end
                end
                ORV64_PTW_RESP: begin
                    if (tlb2ptw_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ORV64_PTW_IDLE;
                    end
                end
                default: r_state <= ORV64_PTW_IDLE;
            endcase
        end
    end

    a_no_stray_mem_resp: assert property (@(posedge tlb_clkg) disable iff (!rstn)
        (r_state != ORV64_PTW_MEM_WAIT) |-> !mem2ptw_resp_valid);

    assign ptw2tlb_req_ready  = r_req_ready;
    assign ptw2tlb_resp_valid = r_resp_valid;
    assign ptw2tlb_resp       = r_resp;
    assign ptw2mem_req_valid  = r_mem_req_valid;
    assign ptw2mem_req_paddr  = r_paddr;
    assign ptw_busy           = r_busy;

endmodule

// File: tb/tb_orv64_ptw_walker.sv
// Directed bench for orv64_ptw_walker: vector table of walks plus backpressure and reset sequences.
module tb_orv64_ptw_walker;
    import orv64_ptw_walker_pkg::*;

    logic                   tlb_clkg = 1'b0;
    logic                   rstn;
    orv64_csr_satp_t        satp;
    logic                   tlb2ptw_req_valid;
    orv64_tlb_ptw_if_req_t  tlb2ptw_req;
    logic                   ptw2tlb_req_ready;
    logic                   ptw2tlb_resp_valid;
    orv64_tlb_ptw_if_resp_t ptw2tlb_resp;
    logic                   tlb2ptw_resp_ready;
    logic                   ptw2mem_req_valid;
    logic [55:0]            ptw2mem_req_paddr;
    logic                   mem2ptw_req_ready;
    logic                   mem2ptw_resp_valid;
    logic [63:0]            mem2ptw_resp_data;
    logic                   mem2ptw_resp_err;
    logic                   ptw_busy;

    orv64_ptw_walker #(.PADDR_WIDTH(56), .NUM_LEVELS(3)) dut (
        .tlb_clkg           (tlb_clkg),
        .rstn               (rstn),
        .satp               (satp),
        .tlb2ptw_req_valid  (tlb2ptw_req_valid),
        .tlb2ptw_req        (tlb2ptw_req),
        .ptw2tlb_req_ready  (ptw2tlb_req_ready),
        .ptw2tlb_resp_valid (ptw2tlb_resp_valid),
        .ptw2tlb_resp       (ptw2tlb_resp),
        .tlb2ptw_resp_ready (tlb2ptw_resp_ready),
        .ptw2mem_req_valid  (ptw2mem_req_valid),
        .ptw2mem_req_paddr  (ptw2mem_req_paddr),
        .mem2ptw_req_ready  (mem2ptw_req_ready),
        .mem2ptw_resp_valid (mem2ptw_resp_valid),
        .mem2ptw_resp_data  (mem2ptw_resp_data),
        .mem2ptw_resp_err   (mem2ptw_resp_err),
        .ptw_busy           (ptw_busy)
    );

    always #5 tlb_clkg = ~tlb_clkg;

    typedef struct {
        string              name;
        logic [26:0]        vpn;
        orv64_access_type_t acc;
        logic [2:0][63:0]   pte;
        int                 err_idx;
        int                 nreads;
        logic [2:0][55:0]   paddr;
        logic               excp;
        logic [3:0]         cause;
        logic [1:0]         lvl;
        logic [63:0]        rpte;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memory model state: PTE read k of the current walk returns cur_pte[k].
    logic [2:0][63:0] cur_pte;
    int               cur_err   = -1;
    int               walk_base = 0;
    bit               mute      = 1'b0;
    int               rd_count  = 0;
    logic [55:0]      rd_addr [256];
    bit               pend;
    int               k;

    always begin
        @(posedge tlb_clkg);
        pend = 1'b0;
        if (rstn && ptw2mem_req_valid && mem2ptw_req_ready) begin
            if (rd_count < 256) rd_addr[rd_count] = ptw2mem_req_paddr;
            k        = rd_count - walk_base;
            pend     = !mute;
            rd_count = rd_count + 1;
        end
        @(negedge tlb_clkg);
        if (pend && rstn) begin
            mem2ptw_resp_valid = 1'b1;
            mem2ptw_resp_data  = (k >= 0 && k < 3) ? cur_pte[k] : 64'h0;
            mem2ptw_resp_err   = (k == cur_err);
        end else begin
            mem2ptw_resp_valid = 1'b0;
            mem2ptw_resp_data  = '0;
            mem2ptw_resp_err   = 1'b0;
        end
    end

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] fl);
        return {10'b0, ppn, 2'b00, fl};
    endfunction

    function automatic vec_t mkv(input string name, input logic [26:0] vpn, input orv64_access_type_t acc,
                                 input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2,
                                 input int err_idx, input int nreads,
                                 input logic [55:0] a0, input logic [55:0] a1, input logic [55:0] a2,
                                 input logic excp, input logic [3:0] cause, input logic [1:0] lvl,
                                 input logic [63:0] rpte);
        vec_t v;
        v.name = name; v.vpn = vpn; v.acc = acc;
        v.pte[0] = p0; v.pte[1] = p1; v.pte[2] = p2;
        v.err_idx = err_idx; v.nreads = nreads;
        v.paddr[0] = a0; v.paddr[1] = a1; v.paddr[2] = a2;
        v.excp = excp; v.cause = cause; v.lvl = lvl; v.rpte = rpte;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [26:0] vpn, input orv64_access_type_t acc);
        int cyc;
        cyc = 0;
        while (!ptw2tlb_req_ready && cyc < 50) begin
            @(negedge tlb_clkg);
            cyc++;
        end
        chk("issue.req_ready", {63'b0, ptw2tlb_req_ready}, 64'd1);
        satp                        = '0;
        satp.ppn                    = 44'h80000;
        tlb2ptw_req.req_vpn         = vpn;
        tlb2ptw_req.req_access_type = acc;
        tlb2ptw_req_valid           = 1'b1;
        @(negedge tlb_clkg);
        tlb2ptw_req_valid = 1'b0;
        satp.ppn          = 44'hABCDE;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int base;
        cur_pte   = v.pte;
        cur_err   = v.err_idx;
        base      = rd_count;
        walk_base = rd_count;
        issue(v.vpn, v.acc);
        cyc = 1;
        while (!ptw2tlb_resp_valid && cyc < 100) begin
            @(negedge tlb_clkg);
            cyc++;
        end
        chk({v.name, ".latency"}, 64'(cyc), 64'(2 * v.nreads + 1));
        chk({v.name, ".excp"}, {63'b0, ptw2tlb_resp.resp_excp_valid}, {63'b0, v.excp});
        chk({v.name, ".cause"}, {60'b0, ptw2tlb_resp.resp_excp_cause}, {60'b0, v.cause});
        chk({v.name, ".lvl"}, {62'b0, ptw2tlb_resp.resp_lvl}, {62'b0, v.lvl});
        chk({v.name, ".pte"}, ptw2tlb_resp.resp_pte, v.rpte);
        chk({v.name, ".reads"}, 64'(rd_count - base), 64'(v.nreads));
        for (int i = 0; i < v.nreads && i < 3; i++)
            chk($sformatf("%s.paddr%0d", v.name, i), {8'b0, rd_addr[base + i]}, {8'b0, v.paddr[i]});
        @(negedge tlb_clkg);
        chk({v.name, ".idle_ready"}, {62'b0, ptw2tlb_req_ready, ptw2tlb_resp_valid}, 64'b10);
    endtask

    initial begin
        logic [63:0] ptr1, ptr2, leaf4k;
        bit stable;
        int cyc;
        int base;

        rstn               = 1'b0;
        satp               = '0;
        tlb2ptw_req_valid  = 1'b0;
        tlb2ptw_req        = '0;
        tlb2ptw_resp_ready = 1'b1;
        mem2ptw_req_ready  = 1'b1;
        mem2ptw_resp_valid = 1'b0;
        mem2ptw_resp_data  = '0;
        mem2ptw_resp_err   = 1'b0;
        cur_pte            = '0;

        repeat (3) @(negedge tlb_clkg);
        chk("rst.req_ready", {63'b0, ptw2tlb_req_ready}, 64'd1);
        chk("rst.outs", {61'b0, ptw2tlb_resp_valid, ptw2mem_req_valid, ptw_busy}, 64'd0);
        chk("rst.payload", ptw2tlb_resp.resp_pte, 64'd0);
        rstn = 1'b1;
        @(negedge tlb_clkg);

        ptr1   = mk_pte(44'h80001, 8'h01);
        ptr2   = mk_pte(44'h80002, 8'h01);
        leaf4k = mk_pte(44'h12345, 8'hCF);
        vecs.push_back(mkv("4k", 27'h0012003, ORV64_ACCESS_LOAD, ptr1, ptr2, leaf4k, -1, 3,
                           56'h80000000, 56'h80001480, 56'h80002018, 1'b0, 4'd0, 2'd0, leaf4k));
        vecs.push_back(mkv("2m", 27'h0012003, ORV64_ACCESS_LOAD, ptr1, mk_pte(44'h12200, 8'hCF), 64'h0, -1, 2,
                           56'h80000000, 56'h80001480, 56'h0, 1'b0, 4'd0, 2'd1, mk_pte(44'h12200, 8'hCF)));
        vecs.push_back(mkv("2m_mis", 27'h0012003, ORV64_ACCESS_LOAD, ptr1, mk_pte(44'h12201, 8'hCF), 64'h0, -1, 2,
                           56'h80000000, 56'h80001480, 56'h0, 1'b1, 4'd13, 2'd0, 64'h0));
        vecs.push_back(mkv("root_inv", 27'h0012003, ORV64_ACCESS_STORE, mk_pte(44'h80001, 8'h00), 64'h0, 64'h0, -1, 1,
                           56'h80000000, 56'h0, 56'h0, 1'b1, 4'd15, 2'd0, 64'h0));
        vecs.push_back(mkv("acc_err2", 27'h0012003, ORV64_ACCESS_FETCH, ptr1, ptr2, leaf4k, 1, 2,
                           56'h80000000, 56'h80001480, 56'h0, 1'b1, 4'd1, 2'd0, 64'h0));
        vecs.push_back(mkv("l0_ptr", 27'h0012003, ORV64_ACCESS_LOAD, ptr1, ptr2, mk_pte(44'h80003, 8'h01), -1, 3,
                           56'h80000000, 56'h80001480, 56'h80002018, 1'b1, 4'd13, 2'd0, 64'h0));
        vecs.push_back(mkv("l0_w_only", 27'h0012003, ORV64_ACCESS_AMO, ptr1, ptr2, mk_pte(44'h80003, 8'h05), -1, 3,
                           56'h80000000, 56'h80001480, 56'h80002018, 1'b1, 4'd15, 2'd0, 64'h0));
        vecs.push_back(mkv("1g", 27'h0140E01, ORV64_ACCESS_FETCH, mk_pte(44'h40000, 8'hCB), 64'h0, 64'h0, -1, 1,
                           56'h80000028, 56'h0, 56'h0, 1'b0, 4'd0, 2'd2, mk_pte(44'h40000, 8'hCB)));
        vecs.push_back(mkv("1g_mis", 27'h0140E01, ORV64_ACCESS_FETCH, mk_pte(44'h40200, 8'hCB), 64'h0, 64'h0, -1, 1,
                           56'h80000028, 56'h0, 56'h0, 1'b1, 4'd12, 2'd0, 64'h0));
        vecs.push_back(mkv("acc_err1", 27'h0012003, ORV64_ACCESS_STORE, ptr1, ptr2, leaf4k, 0, 1,
                           56'h80000000, 56'h0, 56'h0, 1'b1, 4'd7, 2'd0, 64'h0));
        vecs.push_back(mkv("acc_err3", 27'h0012003, ORV64_ACCESS_LOAD, ptr1, ptr2, leaf4k, 2, 3,
                           56'h80000000, 56'h80001480, 56'h80002018, 1'b1, 4'd5, 2'd0, 64'h0));
        vecs.push_back(mkv("4k_x", 27'h0140E01, ORV64_ACCESS_FETCH, ptr1, ptr2, mk_pte(44'h55555, 8'h09), -1, 3,
                           56'h80000028, 56'h80001038, 56'h80002008, 1'b0, 4'd0, 2'd0, mk_pte(44'h55555, 8'h09)));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure on both the memory request and the TLB response.
        cur_pte           = vecs[0].pte;
        cur_err           = -1;
        base              = rd_count;
        walk_base         = rd_count;
        mem2ptw_req_ready = 1'b0;
        tlb2ptw_resp_ready = 1'b0;
        issue(27'h0012003, ORV64_ACCESS_LOAD);
        stable = 1'b1;
        repeat (5) begin
            if (!(ptw2mem_req_valid && ptw2mem_req_paddr == 56'h80000000)) stable = 1'b0;
            @(negedge tlb_clkg);
        end
        if (!(ptw2mem_req_valid && ptw2mem_req_paddr == 56'h80000000)) stable = 1'b0;
        chk("bp.mem_req_hold", {63'b0, stable}, 64'd1);
        chk("bp.no_read_while_held", 64'(rd_count - base), 64'd0);
        mem2ptw_req_ready = 1'b1;
        cyc = 0;
        while (!ptw2tlb_resp_valid && cyc < 100) begin
            @(negedge tlb_clkg);
            cyc++;
        end
        chk("bp.resp_seen", {63'b0, ptw2tlb_resp_valid}, 64'd1);
        stable = 1'b1;
        repeat (4) begin
            if (!(ptw2tlb_resp_valid && ptw2tlb_resp.resp_pte == leaf4k && ptw2tlb_resp.resp_lvl == 2'd0
                  && !ptw2tlb_resp.resp_excp_valid)) stable = 1'b0;
            @(negedge tlb_clkg);
        end
        chk("bp.resp_hold", {63'b0, stable}, 64'd1);
        chk("bp.resp_still_valid", {63'b0, ptw2tlb_resp_valid}, 64'd1);
        tlb2ptw_resp_ready = 1'b1;
        @(negedge tlb_clkg);
        chk("bp.idle_ready", {62'b0, ptw2tlb_req_ready, ptw2tlb_resp_valid}, 64'b10);
        chk("bp.reads", 64'(rd_count - base), 64'd3);
        chk("bp.paddr2", {8'b0, rd_addr[base + 2]}, 64'h80002018);

        // Reset while waiting on a memory response that never arrives.
        mute      = 1'b1;
        walk_base = rd_count;
        issue(27'h0012003, ORV64_ACCESS_LOAD);
        cyc = 0;
        while (!(ptw_busy && !ptw2mem_req_valid) && cyc < 50) begin
            @(negedge tlb_clkg);
            cyc++;
        end
        chk("rstmid.in_wait", {62'b0, ptw_busy, ptw2mem_req_valid}, 64'b10);
        @(negedge tlb_clkg);
        rstn = 1'b0;
        @(negedge tlb_clkg);
        chk("rstmid.req_ready", {63'b0, ptw2tlb_req_ready}, 64'd1);
        chk("rstmid.outs", {61'b0, ptw2tlb_resp_valid, ptw2mem_req_valid, ptw_busy}, 64'd0);
        chk("rstmid.payload_pte", ptw2tlb_resp.resp_pte, 64'd0);
        chk("rstmid.payload_misc", {57'b0, ptw2tlb_resp.resp_lvl, ptw2tlb_resp.resp_excp_valid,
                                    ptw2tlb_resp.resp_excp_cause}, 64'd0);
        rstn = 1'b1;
        mute = 1'b0;
        @(negedge tlb_clkg);
        run_vec(vecs[7]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/orv64_ptw_walker.md
# orv64_ptw_walker

Sv39 hardware page-table walker serving one orv64 TLB. Accepts a single translation request on the TLB→PTW request channel, walks up to three levels of page tables through a single-outstanding memory read port, and returns the leaf PTE, its level, or a page/access fault on the PTW→TLB response channel. Sits between one TLB instance and the L1/L2 memory path; one instance per TLB.

## Interface
Parameters:
- PADDR_WIDTH, 56, physical address width of the memory port
- NUM_LEVELS, 3, page-table levels (Sv39); equals ORV64_NUM_PAGE_LEVELS

Ports:
- tlb_clkg  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- satp  in  orv64_csr_satp_t  root PPN; sampled at request acceptance
- tlb2ptw_req_valid  in  1  walk request valid
- tlb2ptw_req  in  orv64_tlb_ptw_if_req_t  req_vpn, req_access_type
- ptw2tlb_req_ready  out  1  walker can accept a request
- ptw2tlb_resp_valid  out  1  walk result valid
- ptw2tlb_resp  out  orv64_tlb_ptw_if_resp_t  resp_pte, resp_lvl, resp_excp_valid, resp_excp_cause
- tlb2ptw_resp_ready  in  1  TLB accepts result
- ptw2mem_req_valid  out  1  PTE read request
- ptw2mem_req_paddr  out  PADDR_WIDTH  8-byte-aligned PTE address
- mem2ptw_req_ready  in  1  memory accepts read
- mem2ptw_resp_valid  in  1  read data valid (no ready; walker always accepts in WAIT)
- mem2ptw_resp_data  in  64  PTE
- mem2ptw_resp_err  in  1  bus/access error on read
- ptw_busy  out  1  state != IDLE

## Operation
- States: IDLE, MEM_REQ, MEM_WAIT, RESP.
- IDLE: ptw2tlb_req_ready=1. On valid&ready: latch vpn, access type, a = satp.ppn<<12, lvl=NUM_LEVELS-1 → MEM_REQ.
- MEM_REQ: ptw2mem_req_valid=1, paddr = a + vpn[9*lvl+:9]*8 (truncated to PADDR_WIDTH). Held stable until mem2ptw_req_ready → MEM_WAIT.
- MEM_WAIT: on mem2ptw_resp_valid classify PTE:
  - resp_err → access fault (fetch 1, load 5, store/AMO 7) → RESP.
  - V=0, or R=0&W=1 → page fault (fetch 12, load 13, store/AMO 15) → RESP.
  - R|X (leaf): if lvl>0 and ppn[9*lvl-1:0]≠0 → page fault (misaligned superpage); else success, resp_lvl=lvl → RESP.
  - pointer: lvl==0 → page fault; else a = pte.ppn<<12, lvl-1 → MEM_REQ.
- RESP: ptw2tlb_resp_valid=1, payload held stable until tlb2ptw_resp_ready → IDLE. On fault resp_pte=0, resp_lvl=0.
- A/D, U/SUM and R/W/X permission checks are the TLB's job; walker never modifies PTEs.
- Fault cause selection uses the shared access-type→cause function (orv64_get_fault_type for page faults, orv64_get_excp_perm_type for access faults).

## Timing
- Reset: state IDLE; ptw2tlb_req_ready=1, ptw2tlb_resp_valid=0, ptw2mem_req_valid=0, ptw_busy=0, latched payload 0.
- One request in flight; ptw2tlb_req_ready=0 outside IDLE.
- Zero-wait memory (ready same cycle, data next cycle): accept at cycle 0 → resp_valid at cycle 2·(levels read)+1: 4K page cycle 7, 2M cycle 5, 1G cycle 3.
- Response accepted same cycle it is presented → req_ready again next cycle; back-to-back walks lose one cycle.
- mem2ptw_resp_valid outside MEM_WAIT is ignored (assertion in sim).
- satp changes after acceptance do not affect the current walk.
- Reset mid-walk: immediate return to IDLE; memory side shares rstn, so no stale response drains.

## Structure
- orv64_typedef_pkg: orv64_ptw_state_t enum; reuse orv64_pte_t, orv64_ptw_lvl_t, orv64_vpn_t, request/response structs.
- orv64_func_pkg: fault-cause functions already shared with the TLB.
- One combinational sub-module orv64_pte_classifier (pte, lvl → is_invalid, is_leaf, is_misaligned).

## Test plan
- satp.ppn=0x80000, vpn=0x0_0001_2003, three valid pointer/leaf PTEs → paddrs 0x80000000+8·vpn[26:18], …; resp_lvl=0, resp_pte=leaf, valid at cycle 7.
- Level-1 leaf with ppn[8:0]=0 → resp_lvl=1, two reads; same with ppn[8:0]=0x1 → load page fault 13.
- Root PTE V=0 for store → resp_excp_cause 15 after one read; pte=0.
- mem2ptw_resp_err on second read for fetch → cause 1, no third read issued.
- Level-0 PTE non-leaf (R=X=0, V=1) → page fault; R=0,W=1 → page fault.
- Backpressure: mem ready low 5 cycles and TLB resp_ready low 4 cycles → paddr/payload stable, no extra reads; rstn mid-MEM_WAIT → IDLE, outputs at reset values next cycle.
